// File: rtl/mul_selftest_pkg.sv
// Shared encodings and default constants for the multiplier self-test controller.
package mul_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UNS = 2'b00;
    localparam logic [1:0] MODE_SGN = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;

    localparam logic [31:0] DEF_SEED_A = 32'h0000_0001;
    localparam logic [31:0] DEF_SEED_B = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_MASK_A = 32'h8020_0003;
    localparam logic [31:0] DEF_MASK_B = 32'h8000_0063;

endpackage

// File: rtl/lfsr.sv
// Galois LFSR (right shift, tap mask XORed in when the dropped bit is 1).
// load reseeds; step advances one state. Seed must be nonzero.
module lfsr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] SEED = 1,
    parameter logic [W-1:0] MASK = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= SEED;
        else if (load) q <= SEED;
        else if (step) q <= (q >> 1) ^ (q[0] ? MASK : '0);
    end

endmodule

// File: rtl/st_exp_pipe.sv
// Expected-result delay line: DEPTH stages of {valid,data}; only the valid bits are reset.
// pend_valid flags valid entries other than the tail, i.e. what survives the next shift.
module st_exp_pipe #(
    parameter int DW    = 64,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          tail_valid,
    output logic [DW-1:0] tail_data,
    output logic          any_valid,
    output logic          pend_valid
);

    localparam logic [DEPTH-1:0] TAIL_BIT = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end

    assign tail_valid = vld[DEPTH-1];
    assign tail_data  = dat[DEPTH-1];
    assign any_valid  = |vld;
    assign pend_valid = |(vld & ~TAIL_BIT);

endmodule

// File: rtl/mul_selftest_ctl.sv
// Self-test controller for pipelined multipliers: LFSR operands out, golden products checked LAT later.
// Optional macro FIRST_ERR_CAPTURE_EN builds the first-error capture registers (fe_*), else they read 0.
module mul_selftest_ctl
    import mul_selftest_pkg::*;
#(
    parameter int          W      = 32,
    parameter int          LAT    = 8,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] SEED_A = DEF_SEED_A,
    parameter logic [31:0] SEED_B = DEF_SEED_B,
    parameter logic [31:0] MASK_A = DEF_MASK_A,
    parameter logic [31:0] MASK_B = DEF_MASK_B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode_sel,
    input  logic [CNT_W-1:0] num_vec,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    output logic             dut_mode,
    input  logic [2*W-1:0]   dut_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [CNT_W-1:0] fe_index,
    output logic [2*W-1:0]   fe_got,
    output logic [2*W-1:0]   fe_exp
);

    state_t           state, state_nxt;
    logic             issue, clear, issue_vld, mode_nxt, drained, mism;
    logic [W-1:0]     lfsr_a, lfsr_b;
    logic [CNT_W-1:0] issued, issued_nxt;
    logic [2*W-1:0]   ext_a, ext_b, golden, tail_data;
    logic             tail_valid, any_valid, pend_valid;

    lfsr #(.W(W), .SEED(W'(SEED_A)), .MASK(W'(MASK_A))) u_lfsr_a (
        .clk(clk), .rst(rst), .load(clear), .step(issue), .q(lfsr_a)
    );
    lfsr #(.W(W), .SEED(W'(SEED_B)), .MASK(W'(MASK_B))) u_lfsr_b (
        .clk(clk), .rst(rst), .load(clear), .step(issue), .q(lfsr_b)
    );

    // Sign/zero-extend then take the low 2W bits: correct for both signednesses.
    assign ext_a  = {{W{dut_mode & dut_a[W-1]}}, dut_a};
    assign ext_b  = {{W{dut_mode & dut_b[W-1]}}, dut_b};
    assign golden = ext_a * ext_b;

    // Golden enters the pipe as the DUT samples the operands, so the tail lines up with dut_res.
    st_exp_pipe #(.DW(2*W), .DEPTH(LAT)) u_exp_pipe (
        .clk(clk), .rst(rst), .in_valid(issue_vld), .in_data(golden),
        .tail_valid(tail_valid), .tail_data(tail_data),
        .any_valid(any_valid), .pend_valid(pend_valid)
    );

    assign issued_nxt = issued + CNT_W'(1);
    assign mism       = tail_valid && (dut_res != tail_data);
    // Done follows the final compare directly: drained once at most the tail is still valid.
    assign drained    = !issue_vld && (!any_valid || (tail_valid && !pend_valid));

    always_comb begin
        case (mode_sel)
            MODE_SGN: mode_nxt = 1'b1;
            MODE_ALT: mode_nxt = issued[0];
            default:  mode_nxt = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    clear     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (num_vec != '0 && issued_nxt == num_vec) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (drained) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            dut_a     <= '0;
            dut_b     <= '0;
            dut_mode  <= 1'b0;
            issued    <= '0;
            issue_vld <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            issue_vld <= issue;
            if (issue) begin
                dut_a    <= lfsr_a;
                dut_b    <= lfsr_b;
                dut_mode <= mode_nxt;
                issued   <= issued_nxt;
            end
            if (clear) begin
                issued    <= '0;
                vec_count <= '0;
                err_count <= '0;
                err_flag  <= 1'b0;
            end else if (tail_valid) begin
                vec_count <= vec_count + CNT_W'(1);
                if (mism) begin
                    err_flag <= 1'b1;
                    if (err_count != '1) err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fe_index <= '0;
            fe_got   <= '0;
            fe_exp   <= '0;
        end else if (clear) begin
            fe_index <= '0;
            fe_got   <= '0;
            fe_exp   <= '0;
        end else if (mism && !err_flag) begin
            fe_index <= vec_count;
            fe_got   <= dut_res;
            fe_exp   <= tail_data;
        end
    end
`else
    assign fe_index = '0;
    assign fe_got   = '0;
    assign fe_exp   = '0;
`endif

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_selftest_ctl.sv
// Bench for mul_selftest_ctl: behavioural multiplier DUT with optional bit-flip, operand scoreboard.
module tb_mul_selftest_ctl;

    localparam int W = 32;
    localparam int LAT = 8;
    localparam int CNT_W = 32;
    localparam logic [31:0] SA = 32'h0000_0001;
    localparam logic [31:0] SB = 32'hDEAD_BEEF;
    localparam logic [31:0] MA = 32'h8020_0003;
    localparam logic [31:0] MB = 32'h8000_0063;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
    } op_t;

    logic             clk = 1'b0, rst = 1'b0;
    logic             start = 1'b0, stop = 1'b0, start6 = 1'b0, stop6 = 1'b0;
    logic [1:0]       mode_sel = 2'b00;
    logic [CNT_W-1:0] num_vec = '0;
    logic [3:0]       num_vec6 = '0;

    logic [W-1:0]     dut_a, dut_b, dut_a6, dut_b6;
    logic             dut_mode, dut_mode6;
    logic [2*W-1:0]   dut_res, fe_got, fe_exp, fe_got6, fe_exp6;
    logic             busy, done, err_flag, busy6, done6, flag6;
    logic [CNT_W-1:0] vec_count, err_count, fe_index;
    logic [3:0]       vec6, err6, fe_index6;
    logic [2*W-1:0]   dut_res6 = '0;

    op_t  sb[$];
    int   checks = 0, passes = 0;
    logic flip_en = 1'b0;
    logic [W-1:0] flip_a = '0, flip_b = '0;
    logic [2*W-1:0] mpipe [LAT];

    always #5 clk = ~clk;

    mul_selftest_ctl #(.W(W), .LAT(LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_sel(mode_sel), .num_vec(num_vec),
        .dut_a(dut_a), .dut_b(dut_b), .dut_mode(dut_mode), .dut_res(dut_res),
        .busy(busy), .done(done), .vec_count(vec_count), .err_count(err_count), .err_flag(err_flag),
        .fe_index(fe_index), .fe_got(fe_got), .fe_exp(fe_exp)
    );

    mul_selftest_ctl #(.W(W), .LAT(LAT), .CNT_W(4)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .stop(stop6), .mode_sel(mode_sel), .num_vec(num_vec6),
        .dut_a(dut_a6), .dut_b(dut_b6), .dut_mode(dut_mode6), .dut_res(dut_res6),
        .busy(busy6), .done(done6), .vec_count(vec6), .err_count(err6), .err_flag(flag6),
        .fe_index(fe_index6), .fe_got(fe_got6), .fe_exp(fe_exp6)
    );

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic m);
        if (m) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] lfsr_next(logic [31:0] q, logic [31:0] mask);
        return (q >> 1) ^ (q[0] ? mask : 32'h0);
    endfunction

    // Behavioural pipelined multiplier, LAT cycles from operand sample to result.
    always @(posedge clk) begin
        logic [63:0] p;
        p = ref_mul(dut_a, dut_b, dut_mode);
        if (flip_en && dut_a == flip_a && dut_b == flip_b) p[0] = ~p[0];
        mpipe[0] <= p;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign dut_res = mpipe[LAT-1];

    task automatic sb_fill(int n, logic [1:0] msel);
        logic [31:0] qa, qb;
        logic        m;
        qa = SA;
        qb = SB;
        for (int i = 0; i < n; i++) begin
            m = (msel == 2'b01) ? 1'b1 : (msel == 2'b10) ? i[0] : 1'b0;
            sb.push_back('{a: qa, b: qb, m: m});
            qa = lfsr_next(qa, MA);
            qb = lfsr_next(qb, MB);
        end
    endtask

    task automatic do_start(logic [1:0] msel, int n);
        @(negedge clk);
        mode_sel = msel;
        num_vec  = CNT_W'(n);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_state got busy=%b done=%b exp 0/0", busy, done); else passes++;
        checks++; if ({dut_a, dut_b, dut_mode} !== '0) $display("FAIL reset_ops got %h exp 0", {dut_a, dut_b, dut_mode}); else passes++;
        checks++; if ({vec_count, err_count, err_flag} !== '0) $display("FAIL reset_cnt got %h exp 0", {vec_count, err_count, err_flag}); else passes++;
        checks++; if ({fe_index, fe_got, fe_exp} !== '0) $display("FAIL reset_fe got %h exp 0", {fe_index, fe_got, fe_exp}); else passes++;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset got busy=%b done=%b exp 0/0", busy, done); else passes++;
    endtask

    task automatic test_basic;
        op_t e;
        int  cyc;
        sb_fill(100, 2'b00);
        do_start(2'b00, 100);
        checks++; if (busy !== 1'b1 || vec_count !== '0) $display("FAIL basic_started got busy=%b vec=%0d exp 1/0", busy, vec_count); else passes++;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL basic_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        cyc = 100;
        while (!done && cyc < 300) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 109) $display("FAIL basic_done_latency got %0d exp 109", cyc); else passes++;
        checks++; if (vec_count !== 100) $display("FAIL basic_vec got %0d exp 100", vec_count); else passes++;
        checks++; if (err_count !== 0 || err_flag !== 1'b0) $display("FAIL basic_err got %0d/%b exp 0/0", err_count, err_flag); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %b exp 0", busy); else passes++;
    endtask

    task automatic test_first_error;
        op_t e;
        int  cyc;
        logic [31:0] qa, qb;
        qa = SA; qb = SB;
        for (int i = 0; i < 37; i++) begin qa = lfsr_next(qa, MA); qb = lfsr_next(qb, MB); end
        flip_a = qa; flip_b = qb; flip_en = 1'b1;
        sb_fill(64, 2'b01);
        do_start(2'b01, 64);
        checks++; if (err_flag !== 1'b0 || vec_count !== '0) $display("FAIL ferr_cleared got flag=%b vec=%0d exp 0/0", err_flag, vec_count); else passes++;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL ferr_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (done !== 1'b1) $display("FAIL ferr_done got %b exp 1", done); else passes++;
        checks++; if (err_count !== 1 || err_flag !== 1'b1) $display("FAIL ferr_count got %0d/%b exp 1/1", err_count, err_flag); else passes++;
        checks++; if (vec_count !== 64) $display("FAIL ferr_vec got %0d exp 64", vec_count); else passes++;
`ifdef FIRST_ERR_CAPTURE_EN
        checks++; if (fe_index !== 37) $display("FAIL ferr_index got %0d exp 37", fe_index); else passes++;
        checks++; if ((fe_got ^ fe_exp) !== 64'd1) $display("FAIL ferr_xor got %h exp 1", fe_got ^ fe_exp); else passes++;
        checks++; if (fe_exp !== ref_mul(qa, qb, 1'b1)) $display("FAIL ferr_exp got %h exp %h", fe_exp, ref_mul(qa, qb, 1'b1)); else passes++;
`else
        checks++; if ({fe_index, fe_got, fe_exp} !== '0) $display("FAIL ferr_fe_tied got %h exp 0", {fe_index, fe_got, fe_exp}); else passes++;
`endif
        flip_en = 1'b0;
    endtask

    task automatic test_alternate;
        op_t e;
        int  cyc;
        sb_fill(20, 2'b10);
        do_start(2'b10, 20);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL alt_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (vec_count !== 20 || err_count !== 0 || err_flag !== 1'b0)
            $display("FAIL alt_result got vec=%0d err=%0d flag=%b exp 20/0/0", vec_count, err_count, err_flag); else passes++;
    endtask

    task automatic test_stop_restart;
        op_t e;
        int  cyc;
        sb_fill(50, 2'b00);
        do_start(2'b00, 0);
        for (int k = 0; k < 50; k++) begin
            if (k == 10) start = 1'b1;   // ignored while running: no reseed
            @(posedge clk); #1;
            start = 1'b0;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL stop_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL stop_drain got busy=%b done=%b exp 1/0", busy, done); else passes++;
        checks++; if (dut_a !== e.a) $display("FAIL stop_hold got %h exp %h", dut_a, e.a); else passes++;
        cyc = 0;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== LAT) $display("FAIL stop_drain_len got %0d exp %0d", cyc, LAT); else passes++;
        checks++; if (vec_count !== 50 || err_count !== 0) $display("FAIL stop_vec got %0d/%0d exp 50/0", vec_count, err_count); else passes++;
        // start with stop in DONE: stop wins
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(posedge clk); #1; start = 1'b0; stop = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL start_stop_same got done=%b busy=%b exp 1/0", done, busy); else passes++;
        sb_fill(3, 2'b00);
        do_start(2'b00, 3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL restart_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        cyc = 0;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (vec_count !== 3 || done !== 1'b1) $display("FAIL restart_vec got %0d done=%b exp 3/1", vec_count, done); else passes++;
    endtask

    task automatic test_reset_mid_run;
        op_t e;
        sb_fill(20, 2'b01);
        do_start(2'b01, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if ({dut_a, dut_b, dut_mode} !== e) $display("FAIL rmid_op%0d got %h exp %h", k, {dut_a, dut_b, dut_mode}, e); else passes++;
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_state got busy=%b done=%b exp 0/0", busy, done); else passes++;
        checks++; if ({dut_a, dut_b, dut_mode} !== '0) $display("FAIL rmid_ops got %h exp 0", {dut_a, dut_b, dut_mode}); else passes++;
        checks++; if ({vec_count, err_count, err_flag} !== '0) $display("FAIL rmid_cnt got %h exp 0", {vec_count, err_count, err_flag}); else passes++;
        @(negedge clk) rst = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || vec_count !== '0) $display("FAIL rmid_idle got busy=%b vec=%0d exp 0/0", busy, vec_count); else passes++;
    endtask

    task automatic test_saturate;
        int cyc;
        @(negedge clk); mode_sel = 2'b00; num_vec6 = 4'd0; start6 = 1'b1;
        @(posedge clk); #1 start6 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        checks++; if (busy6 !== 1'b1) $display("FAIL sat_busy got %b exp 1", busy6); else passes++;
        stop6 = 1'b1;
        @(posedge clk); #1 stop6 = 1'b0;
        cyc = 0;
        while (!done6 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (done6 !== 1'b1) $display("FAIL sat_done got %b exp 1", done6); else passes++;
        checks++; if (err6 !== 4'd15 || flag6 !== 1'b1) $display("FAIL sat_err got %0d/%b exp 15/1", err6, flag6); else passes++;
        checks++; if (vec6 !== 4'd0) $display("FAIL sat_vec_wrap got %0d exp 0", vec6); else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_first_error();
        test_alternate();
        test_stop_restart();
        test_reset_mid_run();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
